spi_tx: RTL and testbench

- SPI master transmitter that shifts a parallel word out on MOSI, for example to drive an SPI DAC.
- It is the write-side counterpart of the voltmeter's SPI receiver and uses the same bus conventions: ss active-low, sclk idle high, slave samples on the sclk falling edge.
- Sits between the measurement/control logic, which supplies the word and a start pulse, and the board pins.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_clkgen.sv | 44 ++++
 rtl/spi_tx.sv | 121 ++++++++++++
 tb/tb_spi_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI bus timing defaults and FSM state encoding.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LEAD  = 2'b01,
    SHIFT = 2'b10,
    TRAIL = 2'b11
  } state_t;

  // Defaults shared with the receiver so both ends agree on bus timing.
  localparam int DEF_BITS = 16;
  localparam int DEF_HALF = 3;
  localparam int DEF_LEAD = 2;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// rtl/spi_clkgen.sv - sclk phase generator; registered sclk plus end-of-bit strobe.
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int half = DEF_HALF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_run_next,
  output logic o_sclk,
  output logic o_bit_end
);

  localparam int HW = cnt_w(half);
  localparam logic [HW-1:0] HALF_LAST = HW'(half - 1);

  logic [HW-1:0] r_cnt;
  logic          r_hi;
  logic          r_sclk;
  logic          w_half_end;
  logic          w_hi_next;

  assign w_half_end = i_en && (r_cnt == HALF_LAST);
  assign w_hi_next  = i_en ? (r_hi ^ w_half_end) : 1'b0;

  // sclk is computed from the next phase so the output is a plain flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_hi   <= 1'b0;
      r_sclk <= 1'b1;
    end else begin
      if (!i_en || w_half_end) r_cnt <= '0;
      else                     r_cnt <= r_cnt + HW'(1);
      r_hi   <= w_hi_next;
      r_sclk <= !(i_run_next && !w_hi_next);
    end
  end

  assign o_sclk    = r_sclk;
  assign o_bit_end = w_half_end && r_hi;

endmodule

// File: rtl/spi_tx.sv
// rtl/spi_tx.sv - SPI master transmitter (ss low, sclk idle high, slave samples on fall).
// Optional build macro SPI_TX_LSB_FIRST_EN sends the word LSB first.
module spi_tx
  import spi_pkg::*;
#(
  parameter int bits = DEF_BITS,
  parameter int half = DEF_HALF,
  parameter int lead = DEF_LEAD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [bits-1:0] data_in,
  output logic            ss,
  output logic            sclk,
  output logic            mosi,
  output logic            busy,
  output logic            done
);

  localparam int PW = cnt_w((half > lead) ? half : lead);
  localparam int BW = $clog2(bits) + 1;
  localparam logic [PW-1:0] LEAD_LAST = PW'(lead - 1);

  state_t          r_state, w_state_next;
  logic [PW-1:0]   r_lcnt, w_lcnt_next;
  logic [BW-1:0]   r_bcnt, w_bcnt_next;
  logic [bits-1:0] r_shr, w_shr_next;
  logic [bits-1:0] w_shr_shifted;
  logic            r_ss, r_busy, r_done;
  logic            w_done_next;
  logic            w_bit_end;
  logic            w_lead_end;

`ifdef SPI_TX_LSB_FIRST_EN
  assign w_shr_shifted = {1'b0, r_shr[bits-1:1]};
  assign mosi          = r_shr[0];
`else
  assign w_shr_shifted = {r_shr[bits-2:0], 1'b0};
  assign mosi          = r_shr[bits-1];
`endif

  assign w_lead_end = (r_lcnt == LEAD_LAST);

  spi_clkgen #(.half(half)) u_clkgen (
    .clk       (clk),
    .rst       (rst),
    .i_en      (r_state == SHIFT),
    .i_run_next(w_state_next == SHIFT),
    .o_sclk    (sclk),
    .o_bit_end (w_bit_end)
  );

  always_comb begin
    w_state_next = r_state;
    w_lcnt_next  = r_lcnt;
    w_bcnt_next  = r_bcnt;
    w_shr_next   = r_shr;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_shr_next   = data_in;
          w_bcnt_next  = BW'(bits);
          w_lcnt_next  = '0;
          w_state_next = LEAD;
        end
      end
      LEAD: begin
        if (w_lead_end) begin
          w_lcnt_next  = '0;
          w_state_next = SHIFT;
        end else begin
          w_lcnt_next = r_lcnt + PW'(1);
        end
      end
      SHIFT: begin
        if (w_bit_end) begin
          w_shr_next  = w_shr_shifted;
          w_bcnt_next = r_bcnt - BW'(1);
          if (r_bcnt == BW'(1)) w_state_next = TRAIL;
        end
      end
      TRAIL: begin
        if (w_lead_end) begin
          w_lcnt_next  = '0;
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_lcnt_next = r_lcnt + PW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_lcnt  <= '0;
      r_bcnt  <= '0;
      r_shr   <= '0;
      r_ss    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_lcnt  <= w_lcnt_next;
      r_bcnt  <= w_bcnt_next;
      r_shr   <= w_shr_next;
      r_ss    <= (w_state_next == IDLE);
      r_busy  <= (w_state_next != IDLE);
      r_done  <= w_done_next;
    end
  end

  assign ss   = r_ss;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_spi_tx.sv
// tb/tb_spi_tx.sv - self-checking bench for spi_tx (default and small-parameter instances).
module tb_spi_tx;

  localparam int B0 = 16, H0 = 3, L0 = 2;
  localparam int B1 = 8,  H1 = 1, L1 = 1;
`ifdef SPI_TX_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] din0   = '0;
  logic [7:0]  din1   = '0;
  logic ss0, sclk0, mosi0, busy0, done0;
  logic ss1, sclk1, mosi1, busy1, done1;

  spi_tx #(.bits(B0), .half(H0), .lead(L0)) u0 (
    .clk(clk), .rst(rst_n), .start(start0), .data_in(din0),
    .ss(ss0), .sclk(sclk0), .mosi(mosi0), .busy(busy0), .done(done0)
  );

  spi_tx #(.bits(B1), .half(H1), .lead(L1)) u1 (
    .clk(clk), .rst(rst_n), .start(start1), .data_in(din1),
    .ss(ss1), .sclk(sclk1), .mosi(mosi1), .busy(busy1), .done(done1)
  );

  typedef struct {
    int          m;
    logic [31:0] word;
    int          len;
    int          falls;
    int          gap;
    logic        first;
  } frame_t;

  frame_t      fq[$];
  int          checks = 0, passed = 0, fails = 0;
  int          in_f[2], len_c[2], falls_c[2], gap_c[2], fgap[2], done_cnt[2];
  logic [31:0] rx[2];
  logic        psclk[2], first_b[2];

  // Reference: frame length and latency follow directly from the bus timing rules.
  function automatic int exp_len(input int m);
    return (m == 0) ? (2 * L0 + B0 * 2 * H0) : (2 * L1 + B1 * 2 * H1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave-side view of the bus: captures mosi at every sclk fall while ss is low.
  task automatic sample();
    logic s, c, d, dn;
    for (int m = 0; m < 2; m++) begin
      s  = (m == 0) ? ss0   : ss1;
      c  = (m == 0) ? sclk0 : sclk1;
      d  = (m == 0) ? mosi0 : mosi1;
      dn = (m == 0) ? done0 : done1;
      if (!rst_n) begin
        in_f[m]  = 0;
        gap_c[m] = 0;
        psclk[m] = 1'b1;
      end else begin
        if (!s) begin
          if (in_f[m] == 0) begin
            in_f[m] = 1; len_c[m] = 0; falls_c[m] = 0; rx[m] = '0; fgap[m] = gap_c[m];
          end
          len_c[m]++;
          if (psclk[m] && !c) begin
            if (falls_c[m] == 0) first_b[m] = d;
            if (LSB) rx[m] = rx[m] | (32'(d) << falls_c[m]);
            else     rx[m] = {rx[m][30:0], d};
            falls_c[m]++;
          end
        end else if (in_f[m] != 0) begin
          fq.push_back('{m, rx[m], len_c[m], falls_c[m], fgap[m], first_b[m]});
          in_f[m]  = 0;
          gap_c[m] = 1;
        end else begin
          gap_c[m]++;
        end
        if (dn) done_cnt[m]++;
        psclk[m] = c;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
  endtask

  task automatic wait_done(input int m, inout int lat);
    while (!((m == 0) ? done0 : done1) && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic send(input int m, input logic [31:0] d, output int lat);
    if (m == 0) begin start0 = 1'b1; din0 = d[15:0]; end
    else        begin start1 = 1'b1; din1 = d[7:0];  end
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    lat = 1;
    wait_done(m, lat);
  endtask

  task automatic chk_frame(input int m, input logic [31:0] d);
    frame_t f;
    if (fq.size() == 0) begin
      chk("frame_present", 32'd0, 32'd1);
    end else begin
      f = fq.pop_front();
      chk("frame_dut", f.m, m);
      chk("frame_word", f.word, d);
      chk("frame_ss_len", f.len, exp_len(m));
      chk("frame_falls", f.falls, (m == 0) ? B0 : B1);
    end
  endtask

  initial begin
    int     lat, lat2, dc;
    frame_t f;
    logic [31:0] d;
    for (int m = 0; m < 2; m++) begin
      in_f[m] = 0; done_cnt[m] = 0; gap_c[m] = 0; psclk[m] = 1'b1; rx[m] = '0; first_b[m] = 1'b0;
    end

    repeat (3) tick();
    chk("reset_outs0", {ss0, sclk0, mosi0, busy0, done0}, 5'b11000);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_outs0", {ss0, sclk0, mosi0, busy0, done0}, 5'b11000);
      chk("idle_outs1", {ss1, sclk1, mosi1, busy1, done1}, 5'b11000);
    end

    // Single frame with the reference word.
    dc = done_cnt[0];
    send(0, 32'hA5C3, lat);
    chk("single_latency", lat, exp_len(0) + 1);
    chk_frame(0, 32'hA5C3);
    tick();
    chk("single_done_once", done_cnt[0] - dc, 1);

    // Start while busy must neither queue nor corrupt.
    repeat (3) tick();
    dc = done_cnt[0];
    start0 = 1'b1; din0 = 16'h0001;
    tick();
    start0 = 1'b0;
    lat = 1;
    while (!done0 && lat < 400) begin
      if (lat == 40) begin start0 = 1'b1; din0 = 16'hFFFF; end
      else            start0 = 1'b0;
      tick();
      lat++;
    end
    start0 = 1'b0;
    chk("busy_latency", lat, exp_len(0) + 1);
    chk_frame(0, 32'h0001);
    repeat (10) tick();
    chk("busy_one_done", done_cnt[0] - dc, 1);
    chk("busy_no_extra_frame", fq.size(), 0);

    // Back-to-back with start held high.
    start0 = 1'b1; din0 = 16'h8000;
    tick();
    din0 = 16'h7FFF;
    lat = 1;
    wait_done(0, lat);
    tick();
    start0 = 1'b0;
    lat2 = 1;
    wait_done(0, lat2);
    chk("b2b_latency1", lat, exp_len(0) + 1);
    chk("b2b_latency2", lat2, exp_len(0) + 1);
    chk_frame(0, 32'h8000);
    if (fq.size() != 0) begin
      f = fq[0];
      chk("b2b_ss_gap", f.gap, 1);
    end
    chk_frame(0, 32'h7FFF);

    // Reset mid-frame abandons the frame without done.
    repeat (4) tick();
    dc = done_cnt[0];
    start0 = 1'b1; din0 = 16'h3C96;
    tick();
    start0 = 1'b0;
    for (int i = 1; i < 50; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {ss0, sclk0, mosi0, busy0}, 4'b1100);
    tick();
    chk("midrst_done_low", done0, 1'b0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("midrst_no_done", done_cnt[0] - dc, 0);
    chk("midrst_no_frame", fq.size(), 0);
    d = {16'd0, 16'($urandom)};
    send(0, d, lat);
    chk("midrst_next_latency", lat, exp_len(0) + 1);
    chk_frame(0, d);

    // Small-parameter instance, single set bit reveals the bit order.
    tick();
    send(1, 32'h01, lat);
    chk("small_latency", lat, exp_len(1) + 1);
    if (fq.size() != 0) begin
      f = fq[0];
      chk("small_first_bit", f.first, LSB ? 1'b1 : 1'b0);
      chk("small_ss_len18", f.len, 18);
    end
    chk_frame(1, 32'h01);

    // Randomized frames on both instances.
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      d = {16'd0, 16'($urandom)};
      send(0, d, lat);
      chk("rand_latency0", lat, exp_len(0) + 1);
      chk_frame(0, d);
      repeat ($urandom_range(0, 3)) tick();
      d = {24'd0, 8'($urandom)};
      send(1, d, lat);
      chk("rand_latency1", lat, exp_len(1) + 1);
      chk_frame(1, d);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
